bin_to_bcd_decimal: RTL and testbench



---
 rtl/bin_to_bcd_decimal.sv | 149 ++++++++++++++
 tb/tb_bin_to_bcd_decimal.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_decimal.sv
// bin_to_bcd_decimal: sequential binary-to-BCD converter (shift-add-3, one
// input bit per clock) with a registered one-hot decimal decode per digit.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the decode of leading
// zero digits above digit 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last result
// CONV  | one shift-add-3 step per clock, counter runs BIN_W down to 0

module bin_to_bcd_decimal #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [10*DIGITS-1:0]  dec_out
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int ACC_W = 4 * DIGITS;

   // decode of an all-zero result, used as the reset value of dec_out
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [10*DIGITS-1:0] DEC_ZERO = (10*DIGITS)'(1);
`else
   localparam logic [10*DIGITS-1:0] DEC_ZERO = {DIGITS{10'd1}};
`endif

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state, state_nxt;
   logic [BIN_W-1:0]    bin_sr;
   logic [ACC_W-1:0]    acc;
   logic                ovf_trk;
   logic [CNT_W-1:0]    cnt;

   logic [ACC_W-1:0]    acc_adj;
   logic [ACC_W-1:0]    acc_shift;
   logic                shift_out;
   logic                last;
   logic                ovf_fin;
   logic [ACC_W-1:0]    res_bcd;
   logic [10*DIGITS-1:0] res_dec;
   logic [3:0]          dig;
   logic                hi_zero;
   logic                blank;

   assign busy = (state == CONV);
   assign last = (state == CONV) && (cnt == CNT_W'(1));

   // add 3 to every digit >= 5, then shift the next binary bit into the units
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      {shift_out, acc_shift} = {acc_adj, bin_sr[BIN_W-1]};
   end

   // final result: saturate to all 9s if anything ever left the top digit
   always_comb begin
      ovf_fin = ovf_trk | shift_out;
      res_bcd = ovf_fin ? {DIGITS{4'h9}} : acc_shift;
   end

   // one-hot decode per digit, walking from the top digit down so leading zeros are known
   always_comb begin
      res_dec = '0;
      hi_zero = 1'b1;
      dig     = 4'd0;
      blank   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         dig     = res_bcd[4*i +: 4];
         hi_zero = hi_zero && (dig == 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
         blank   = hi_zero && (i != 0);
`else
         blank   = 1'b0;
`endif
         // codes 10..15 shift the one out of the field and decode to all zeros
         if (!blank)
            res_dec[10*i +: 10] = 10'd1 << dig;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (cnt == CNT_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // operand capture and shift-add-3 datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_sr  <= '0;
         acc     <= '0;
         ovf_trk <= 1'b0;
         cnt     <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            bin_sr  <= bin_in;
            acc     <= '0;
            ovf_trk <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
         end
      end else begin
         bin_sr  <= bin_sr << 1;
         acc     <= acc_shift;
         ovf_trk <= ovf_fin;
         cnt     <= cnt - CNT_W'(1);
      end
   end

   // result registers load only on the final conversion edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done     <= 1'b0;
         overflow <= 1'b0;
         bcd_out  <= '0;
         dec_out  <= DEC_ZERO;
      end else begin
         done <= last;
         if (last) begin
            overflow <= ovf_fin;
            bcd_out  <= res_bcd;
            dec_out  <= res_dec;
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_decimal.sv
// Self-checking bench for bin_to_bcd_decimal: a 3-digit and a 2-digit
// instance, table vectors, random operands against an arithmetic model, and
// hand sequences for ignored start, mid-conversion reset and back-to-back use.

module tb_bin_to_bcd_decimal;

   logic        clk = 1'b0;
   logic        rst;
   logic        start3, start2;
   logic [7:0]  bin3, bin2;
   logic        busy3, done3, ovf3, busy2, done2, ovf2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;
   logic [29:0] dec3;
   logic [19:0] dec2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin_to_bcd_decimal #(.BIN_W(8), .DIGITS(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
      .busy(busy3), .done(done3), .overflow(ovf3),
      .bcd_out(bcd3), .dec_out(dec3));

   bin_to_bcd_decimal #(.BIN_W(8), .DIGITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
      .busy(busy2), .done(done2), .overflow(ovf2),
      .bcd_out(bcd2), .dec_out(dec2));

   // reference: decimal digits by division, saturation by comparison with 10^d-1
   task automatic model(input int v, input int d, output logic [11:0] bcd,
                        output logic [29:0] dec, output logic ovf);
      int mx, x, p, digit;
      bit blank;
      mx  = (d == 3) ? 999 : 99;
      ovf = (v > mx);
      x   = ovf ? mx : v;
      bcd = '0;
      dec = '0;
      p   = 1;
      for (int i = 0; i < d; i++) begin
         digit = (x / p) % 10;
         bcd[4*i +: 4] = 4'(digit);
`ifdef LEADING_ZERO_BLANK_EN
         blank = (i > 0) && (x < p);
`else
         blank = 1'b0;
`endif
         if (!blank) dec[10*i + digit] = 1'b1;
         p = p * 10;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic read_out(input int d, output logic [11:0] bcd, output logic [29:0] dec,
                           output logic ovf);
      if (d == 3) begin bcd = bcd3; dec = dec3; ovf = ovf3; end
      else begin bcd = {4'h0, bcd2}; dec = {10'h0, dec2}; ovf = ovf2; end
   endtask

   // start one conversion; n counts negedges after the accepting edge (done expected at n=9)
   task automatic run(input int d, input int v, output logic [11:0] bcd, output logic [29:0] dec,
                      output logic ovf, output int lat, output int bcnt);
      logic b, dn;
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      if (d == 3) begin bin3 = 8'(v); start3 = 1'b1; end
      else        begin bin2 = 8'(v); start2 = 1'b1; end
      @(negedge clk);
      start3 = 1'b0;
      start2 = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge clk);
         b  = (d == 3) ? busy3 : busy2;
         dn = (d == 3) ? done3 : done2;
         if (b) bcnt++;
         if (dn) begin lat = n; break; end
      end
      read_out(d, bcd, dec, ovf);
      @(negedge clk);
      dn = (d == 3) ? done3 : done2;
      check($sformatf("done_one_cycle d%0d v%0d", d, v), {31'd0, dn}, 32'd0);
   endtask

   task automatic conv_check(input int d, input int v);
      logic [11:0] bcd, ebcd;
      logic [29:0] dec, edec;
      logic ovf, eovf;
      int lat, bcnt;
      run(d, v, bcd, dec, ovf, lat, bcnt);
      model(v, d, ebcd, edec, eovf);
      check($sformatf("latency d%0d v%0d", d, v), lat, 9);
      check($sformatf("busy_cycles d%0d v%0d", d, v), bcnt, 8);
      check($sformatf("bcd d%0d v%0d", d, v), {20'd0, bcd}, {20'd0, ebcd});
      check($sformatf("dec d%0d v%0d", d, v), {2'd0, dec}, {2'd0, edec});
      check($sformatf("ovf d%0d v%0d", d, v), {31'd0, ovf}, {31'd0, eovf});
   endtask

   typedef struct {
      int          v;
      int          d;
      logic [11:0] bcd;
      logic        ovf;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [11:0] ebcd, bcd;
      logic [29:0] edec, dec;
      logic        eovf, ovf;
      int          lat, bcnt, dcnt, dn_at, p1, p2;
      logic [11:0] r1, r2;

      tbl[0] = '{0,   3, 12'h000, 1'b0};
      tbl[1] = '{255, 3, 12'h255, 1'b0};
      tbl[2] = '{7,   3, 12'h007, 1'b0};
      tbl[3] = '{100, 3, 12'h100, 1'b0};
      tbl[4] = '{128, 3, 12'h128, 1'b0};
      tbl[5] = '{1,   3, 12'h001, 1'b0};
      tbl[6] = '{123, 2, 12'h099, 1'b1};
      tbl[7] = '{42,  2, 12'h042, 1'b0};
      tbl[8] = '{99,  2, 12'h099, 1'b0};
      tbl[9] = '{100, 2, 12'h099, 1'b1};

      rst = 1'b1; start3 = 1'b0; start2 = 1'b0; bin3 = '0; bin2 = '0;
      repeat (3) @(negedge clk);
      model(0, 3, ebcd, edec, eovf);
      check("reset busy3", {31'd0, busy3}, 32'd0);
      check("reset done3", {31'd0, done3}, 32'd0);
      check("reset ovf3", {31'd0, ovf3}, 32'd0);
      check("reset bcd3", {20'd0, bcd3}, 32'd0);
      check("reset dec3", {2'd0, dec3}, {2'd0, edec});
      model(0, 2, ebcd, edec, eovf);
      check("reset dec2", {12'd0, dec2}, {12'd0, edec[19:0]});
      rst = 1'b0;
      @(negedge clk);
      check("idle busy3", {31'd0, busy3}, 32'd0);

      // table vectors
      for (int i = 0; i < 10; i++) begin
         run(tbl[i].d, tbl[i].v, bcd, dec, ovf, lat, bcnt);
         model(tbl[i].v, tbl[i].d, ebcd, edec, eovf);
         check($sformatf("tbl%0d latency", i), lat, 9);
         check($sformatf("tbl%0d busy_cycles", i), bcnt, 8);
         check($sformatf("tbl%0d bcd", i), {20'd0, bcd}, {20'd0, tbl[i].bcd});
         check($sformatf("tbl%0d ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ovf});
         check($sformatf("tbl%0d dec", i), {2'd0, dec}, {2'd0, edec});
      end

      // random operands on both widths
      for (int i = 0; i < 20; i++) begin
         conv_check(3, int'($urandom_range(0, 255)));
         conv_check(2, int'($urandom_range(0, 255)));
      end

      // start pulses at busy cycles 3 and 5 are ignored
      @(negedge clk);
      bin3 = 8'd255; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      dcnt = 0; dn_at = -1; bcd = '0;
      for (int n = 1; n <= 14; n++) begin
         if (n > 1) @(negedge clk);
         if (done3) begin dcnt++; dn_at = n; bcd = bcd3; end
         start3 = (n == 3 || n == 5);
         if (n == 3 || n == 5) bin3 = 8'd0;
      end
      start3 = 1'b0;
      check("ignored_start done_count", dcnt, 1);
      check("ignored_start done_at", dn_at, 9);
      check("ignored_start bcd", {20'd0, bcd}, 32'h255);

      // reset in the 4th busy cycle aborts with no done
      @(negedge clk);
      bin3 = 8'd200; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      model(0, 3, ebcd, edec, eovf);
      check("abort busy", {31'd0, busy3}, 32'd0);
      check("abort done", {31'd0, done3}, 32'd0);
      check("abort ovf", {31'd0, ovf3}, 32'd0);
      check("abort bcd", {20'd0, bcd3}, 32'd0);
      check("abort dec", {2'd0, dec3}, {2'd0, edec});
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done3 || busy3) dcnt++;
      end
      check("abort no_activity", dcnt, 0);
      conv_check(3, 7);

      // back-to-back with start held: 9 then 99
      @(negedge clk);
      bin3 = 8'd9; start3 = 1'b1;
      @(negedge clk);
      bin3 = 8'd99;
      p1 = -1; p2 = -1; r1 = '0; r2 = '0;
      for (int n = 1; n <= 30; n++) begin
         if (n > 1) @(negedge clk);
         if (done3) begin
            if (p1 < 0) begin p1 = n; r1 = bcd3; end
            else begin p2 = n; r2 = bcd3; start3 = 1'b0; break; end
         end
      end
      start3 = 1'b0;
      check("b2b first_done", p1, 9);
      check("b2b second_done", p2, 18);
      check("b2b first_bcd", {20'd0, r1}, 32'h009);
      check("b2b second_bcd", {20'd0, r2}, 32'h099);
      @(negedge clk);
      check("b2b idle_after", {31'd0, busy3}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
